// File: rtl/game_pkg.sv
// Shared definitions for the memory game: FSM state encoding and default
// widths used by the controller, the address counters and the pattern ROM.
package game_pkg;

  localparam int GAME_ROUND_W = 4;
  localparam int GAME_SYM_W   = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_SHOW   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_PLAY   = 3'd4;
  localparam logic [2:0] S_ACCEPT = 3'd5;
  localparam logic [2:0] S_CHECK  = 3'd6;
  localparam logic [2:0] S_RESULT = 3'd7;

endpackage

// File: rtl/phase_timer.sv
// Up-counter shared by the timed game phases; done flags the compare value.
module phase_timer #(
  parameter int P_TIMER_W = 16
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 clr,
  input  logic                 cnt,
  input  logic [P_TIMER_W-1:0] limit,
  output logic [P_TIMER_W-1:0] value,
  output logic                 done
);

  always_ff @(posedge clk) begin
    if (R || clr) begin
      value <= '0;
    end else if (cnt) begin
      value <= value + 1'b1;
    end
  end

  assign done = (value == limit);

endmodule

// File: rtl/game_controller.sv
// Memory-game sequencer: shows the ROM pattern for each round, then checks the
// player's entries, advancing rounds until a win, a wrong entry or a timeout.
module game_controller
  import game_pkg::*;
#(
  parameter int P_ROUND_W   = GAME_ROUND_W,
  parameter int P_SYM_W     = GAME_SYM_W,
  parameter int P_HOLD      = 4,
  parameter int P_GAP       = 2,
  parameter int P_TIMEOUT   = 64,
  parameter int P_MAX_ROUND = 15,
  parameter int P_TIMER_W   = 16
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 start,
  input  logic                 enter,
  input  logic [P_SYM_W-1:0]   sw,
  input  logic [P_SYM_W-1:0]   rom_fpga,
  input  logic [P_SYM_W-1:0]   rom_user,
  input  logic                 tc_fpga,
  input  logic                 tc_user,
  output logic                 R_fpga,
  output logic                 E_fpga,
  output logic                 R_user,
  output logic                 E_user,
  output logic [P_ROUND_W-1:0] round,
  output logic [P_SYM_W-1:0]   show,
  output logic                 win,
  output logic                 lose,
  output logic [2:0]           state
);

  localparam logic [P_TIMER_W-1:0] HOLD_LAST    = P_TIMER_W'(P_HOLD - 1);
  localparam logic [P_TIMER_W-1:0] GAP_LAST     = P_TIMER_W'(P_GAP - 1);
  localparam logic [P_TIMER_W-1:0] TIMEOUT_LAST = P_TIMER_W'(P_TIMEOUT - 1);
  localparam logic [P_ROUND_W-1:0] LAST_ROUND   = P_ROUND_W'(P_MAX_ROUND);

  logic [2:0]           state_q, state_nx;
  logic [P_ROUND_W-1:0] round_q, round_nx;
  logic                 win_q, win_nx;
  logic                 lose_q, lose_nx;

  logic [P_TIMER_W-1:0] timer_val;
  logic [P_TIMER_W-1:0] timer_limit;
  logic                 timer_done;
  logic                 timer_clr;
  logic                 timer_cnt;

  // Timer restarts from zero on every state change, so each phase sees 0 on entry.
  assign timer_clr = (state_nx != state_q);

  always_comb begin
    timer_cnt   = 1'b0;
    timer_limit = '0;
    case (state_q)
      S_SHOW: begin timer_cnt = 1'b1; timer_limit = HOLD_LAST;    end
      S_GAP:  begin timer_cnt = 1'b1; timer_limit = GAP_LAST;     end
      S_PLAY: begin timer_cnt = 1'b1; timer_limit = TIMEOUT_LAST; end
      default: ;
    endcase
  end

  phase_timer #(.P_TIMER_W(P_TIMER_W)) u_timer (
    .clk   (clk),
    .R     (R),
    .clr   (timer_clr),
    .cnt   (timer_cnt),
    .limit (timer_limit),
    .value (timer_val),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= S_IDLE;
      round_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      round_q <= round_nx;
      win_q   <= win_nx;
      lose_q  <= lose_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    round_nx = round_q;
    win_nx   = win_q;
    lose_nx  = lose_q;
    case (state_q)
      S_IDLE, S_RESULT: begin
        if (start) begin
          state_nx = S_SETUP;
          round_nx = '0;
          win_nx   = 1'b0;
          lose_nx  = 1'b0;
        end
      end
      S_SETUP: state_nx = S_SHOW;
      S_SHOW: begin
        if (timer_done) state_nx = S_GAP;
      end
      S_GAP: begin
        if (timer_done) state_nx = tc_fpga ? S_PLAY : S_SHOW;
      end
      S_PLAY: begin
        // An enter arriving on the timeout cycle still counts.
        if (enter) begin
          if (sw == rom_user) begin
            state_nx = S_ACCEPT;
          end else begin
            state_nx = S_RESULT;
            lose_nx  = 1'b1;
          end
        end else if (timer_done) begin
          state_nx = S_RESULT;
          lose_nx  = 1'b1;
        end
      end
      S_ACCEPT: state_nx = S_CHECK;
      S_CHECK: begin
        if (!tc_user) begin
          state_nx = S_PLAY;
        end else if (round_q == LAST_ROUND) begin
          state_nx = S_RESULT;
          win_nx   = 1'b1;
        end else begin
          state_nx = S_SETUP;
          round_nx = round_q + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    R_fpga = 1'b1;
    R_user = 1'b1;
    E_fpga = 1'b0;
    E_user = 1'b0;
    show   = '0;
    case (state_q)
      S_SHOW: begin
        R_fpga = 1'b0;
        show   = rom_fpga;
        E_fpga = timer_done;
      end
      S_GAP:    R_fpga = 1'b0;
      S_PLAY:   R_user = 1'b0;
      S_ACCEPT: begin R_user = 1'b0; E_user = 1'b1; end
      S_CHECK:  R_user = 1'b0;
      default: ;
    endcase
  end

  assign round = round_q;
  assign win   = win_q;
  assign lose  = lose_q;
  assign state = state_q;

endmodule

// File: doc/game_controller.md
# game_controller

Top-level sequencing FSM for the memory game. It drives the FPGA sequence counter and the user-input counter through their reset, enable and round-limit inputs. Each round it displays the ROM sequence symbol by symbol, then collects and checks player entries, advances the round, and declares win or loss. It sits between the two address counters, the pattern ROM, and the switch/button front end. Buttons arrive already debounced and single-pulsed.

## Interface

Parameters:
- P_ROUND_W, 4, width of round / counter limit
- P_SYM_W, 4, width of a sequence symbol
- P_HOLD, 4, cycles each symbol is shown (≥2)
- P_GAP, 2, blank cycles between symbols (≥1)
- P_TIMEOUT, 64, max PLAY cycles waiting for enter (≥2)
- P_MAX_ROUND, 15, last round index; completing it wins
- P_TIMER_W, 16, phase timer width (must hold max of P_HOLD, P_GAP, P_TIMEOUT)

Ports:
- clk  in  1  system clock
- R  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a game from IDLE or RESULT
- enter  in  1  one-cycle pulse; player confirms sw
- sw  in  P_SYM_W  player's symbol
- rom_fpga  in  P_SYM_W  ROM data at FPGA counter address
- rom_user  in  P_SYM_W  ROM data at user counter address
- tc_fpga  in  1  terminal count from FPGA sequence counter (sticky until its reset)
- tc_user  in  1  terminal count from user counter (sticky until its reset)
- R_fpga, E_fpga  out  1 each  reset/enable to FPGA counter
- R_user, E_user  out  1 each  reset/enable to user counter
- round  out  P_ROUND_W  current round; drives both counters' limit input
- show  out  P_SYM_W  symbol to display (0 when blank)
- win, lose  out  1 each  game result flags
- state  out  3  FSM state, for debug LEDs

## Operation

- States (3-bit): IDLE=0, SETUP=1, SHOW=2, GAP=3, PLAY=4, ACCEPT=5, CHECK=6, RESULT=7.
- All outputs are Moore: decoded from the state, timer, round, win and lose registers only; no combinational input-to-output path.
- IDLE:
  - R_fpga=R_user=1, show=0.
  - start → SETUP, round←0, win←lose←0.
- SETUP (1 cycle):
  - R_fpga=R_user=1.
  - → SHOW, timer←0.
- SHOW:
  - show=rom_fpga, R_fpga=0, R_user=1.
  - Timer counts 0..P_HOLD-1.
  - E_fpga=1 only in the cycle where timer==P_HOLD-1.
  - That cycle → GAP, timer←0.
- GAP:
  - show=0, R_fpga=0.
  - After P_GAP cycles: if tc_fpga → PLAY, else → SHOW.
  - In both cases timer←0.
- Counter contract: the counters assert tc on the E pulse where their count equals round, then wrap to 0.
  - Round r therefore shows r+1 symbols (addresses 0..r).
  - Round r also needs r+1 correct entries.
- PLAY:
  - R_fpga=1, R_user=0, show=0.
  - enter with sw==rom_user → ACCEPT.
  - enter with mismatch → RESULT, lose←1.
  - No enter by timer==P_TIMEOUT-1 → RESULT, lose←1.
  - enter and timeout in the same cycle: enter wins.
- ACCEPT (1 cycle):
  - E_user=1.
  - → CHECK.
- CHECK (1 cycle; tc_user is now valid):
  - tc_user=0 → PLAY, timer←0.
  - tc_user=1 and round==P_MAX_ROUND → RESULT, win←1.
  - tc_user=1 otherwise → SETUP, round←round+1.
- RESULT:
  - R_fpga=R_user=1; win or lose held.
  - start → SETUP, round←0, win←lose←0.
  - enter is ignored.
- start is ignored in every state except IDLE and RESULT.
- round never wraps: P_MAX_ROUND ≤ 2^P_ROUND_W−1 is required.

## Timing

- Reset values (R=1 at a clock edge):
  - state=IDLE, round=0, timer=0, win=0, lose=0, show=0.
  - E_fpga=E_user=0, R_fpga=R_user=1.
- Reset mid-game: takes effect at the next edge from any state and overrides start/enter in the same cycle.
- Latencies:
  - start→SETUP: 1 cycle.
  - SETUP→first symbol visible: 1 cycle.
  - Display of round r: (r+1)·(P_HOLD+P_GAP) cycles.
  - Accepted enter→next PLAY: 3 cycles (ACCEPT, CHECK, PLAY).
- enter is sampled only in PLAY; pulses during SHOW, GAP, ACCEPT and CHECK are dropped.
- E_fpga and E_user are exactly one cycle wide per symbol.

## Structure

- Shared package game_pkg holds:
  - state encoding localparams (S_IDLE..S_RESULT);
  - default widths P_ROUND_W and P_SYM_W, reused by the counters and ROM.
- One sub-module: phase_timer, a P_TIMER_W up-counter with clear, count and a terminal-compare input.
  - Shared by SHOW, GAP and PLAY.
  - The cleared value is loaded on every state entry.

## Test plan

Bench instantiates the real sequence counters and the ROM around the DUT. Parameters: P_HOLD=4, P_GAP=2, P_TIMEOUT=16, P_MAX_ROUND=1.

- Reset, then idle 10 cycles → state=0, R_fpga=R_user=1, win=lose=0, show=0.
- start; ROM[0]=5 → SETUP 1 cycle, then show=5 for 4 cycles, one E_fpga pulse, 2 blank cycles, then PLAY.
- Round 0: enter with sw=5 → ACCEPT, CHECK, SETUP, round=1. Round 1 then shows ROM[0] then ROM[1] (12 display cycles).
- Round 1: correct entries ROM[0], ROM[1] → win=1, state=7. A following enter has no effect; start clears win and round=0.
- Round 0: enter with sw≠ROM[0] → lose=1, state=7 next cycle.
- Timeout and reset:
  - In PLAY, no enter for 16 cycles → lose=1.
  - A separate run asserts R during SHOW → IDLE at the next edge with all reset values.
